// File: rtl/id_ex_hazard_stage_pkg.sv
// Shared types and constants for the ID/EX stage: control word layout,
// the NOP bubble value and the ALU_Op classes emitted by the control unit.
package id_ex_hazard_stage_pkg;

  typedef enum logic [2:0] {
    ALU_OP_R       = 3'b000,
    ALU_OP_I_LOGIC = 3'b001,
    ALU_OP_U       = 3'b010,
    ALU_OP_B       = 3'b011,
    ALU_OP_S       = 3'b100,
    ALU_OP_LOAD    = 3'b101,
    ALU_OP_J       = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic    jal;
    logic    branch;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int          CTRL_W   = $bits(ctrl_t);
  localparam logic [4:0]  REG_X0   = 5'd0;
  localparam ctrl_t       CTRL_NOP = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// Decode-side inputs and execute-side outputs of the ID/EX stage.
// The stage is the slave; the surrounding pipeline (or bench) is the master.
interface id_ex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              Jal_i, Branch_i, Mem_to_Reg_i, Reg_Write_i;
  logic              Mem_Read_i, Mem_Write_i, ALU_Src_i;
  logic [2:0]        ALU_Op_i;
  logic [DATA_W-1:0] PC_i, Read_Data_1_i, Read_Data_2_i, Immediate_i;
  logic [4:0]        Rs1_i, Rs2_i, Rd_i;
  logic [3:0]        Funct_i;
  logic              Flush_i;

  logic              Jal_o, Branch_o, Mem_to_Reg_o, Reg_Write_o;
  logic              Mem_Read_o, Mem_Write_o, ALU_Src_o;
  logic [2:0]        ALU_Op_o;
  logic [DATA_W-1:0] PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o;
  logic [4:0]        Rs1_o, Rs2_o, Rd_o;
  logic [3:0]        Funct_o;
  logic              Stall_o;
  logic [CNT_W-1:0]  Bubble_Count_o;

  modport master (
    output Jal_i, Branch_i, Mem_to_Reg_i, Reg_Write_i, Mem_Read_i, Mem_Write_i,
           ALU_Src_i, ALU_Op_i, PC_i, Read_Data_1_i, Read_Data_2_i, Immediate_i,
           Rs1_i, Rs2_i, Rd_i, Funct_i, Flush_i,
    input  Jal_o, Branch_o, Mem_to_Reg_o, Reg_Write_o, Mem_Read_o, Mem_Write_o,
           ALU_Src_o, ALU_Op_o, PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o,
           Rs1_o, Rs2_o, Rd_o, Funct_o, Stall_o, Bubble_Count_o
  );

  modport slave (
    input  Jal_i, Branch_i, Mem_to_Reg_i, Reg_Write_i, Mem_Read_i, Mem_Write_i,
           ALU_Src_i, ALU_Op_i, PC_i, Read_Data_1_i, Read_Data_2_i, Immediate_i,
           Rs1_i, Rs2_i, Rd_i, Funct_i, Flush_i,
    output Jal_o, Branch_o, Mem_to_Reg_o, Reg_Write_o, Mem_Read_o, Mem_Write_o,
           ALU_Src_o, ALU_Op_o, PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o,
           Rs1_o, Rs2_o, Rd_o, Funct_o, Stall_o, Bubble_Count_o
  );
endinterface

// File: rtl/id_ex_hazard_stage_hazard_detect.sv
// Load-use hazard check: the load now in EX writes a register the ID
// instruction reads. A flush discards the ID instruction, so it masks the stall.
module id_ex_hazard_stage_hazard_detect
  import id_ex_hazard_stage_pkg::*;
(
  input  logic       mem_read_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic [4:0] rs1_id_i,
  input  logic [4:0] rs2_id_i,
  input  logic       flush_i,
  output logic       stall_o
);

  logic rd_live;
  logic rd_match;

  assign rd_live  = (rd_ex_i != REG_X0);
  assign rd_match = (rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i);
  assign stall_o  = mem_read_ex_i && rd_live && rd_match && !flush_i;

endmodule

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use stall generation and bubble insertion.
// A bubble zeroes the control word only; data fields load regardless.
module id_ex_hazard_stage
  import id_ex_hazard_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  id_ex_hazard_stage_if.slave  bus
);

  ctrl_t             ctrl_q, ctrl_d, ctrl_in;
  logic [DATA_W-1:0] pc_q, rd1_q, rd2_q, imm_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [3:0]        funct_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;
  logic              bubble;

  id_ex_hazard_stage_hazard_detect u_hazard_detect (
    .mem_read_ex_i (ctrl_q.mem_read),
    .rd_ex_i       (rd_q),
    .rs1_id_i      (bus.Rs1_i),
    .rs2_id_i      (bus.Rs2_i),
    .flush_i       (bus.Flush_i),
    .stall_o       (stall)
  );

  assign ctrl_in = '{
    jal:        bus.Jal_i,
    branch:     bus.Branch_i,
    mem_to_reg: bus.Mem_to_Reg_i,
    reg_write:  bus.Reg_Write_i,
    mem_read:   bus.Mem_Read_i,
    mem_write:  bus.Mem_Write_i,
    alu_src:    bus.ALU_Src_i,
    alu_op:     alu_op_e'(bus.ALU_Op_i)
  };

  // Flush and stall both produce exactly one bubble; stall is already masked by flush.
  assign bubble = bus.Flush_i || stall;

  always_comb begin
    ctrl_d = ctrl_in;
    cnt_d  = cnt_q;
    if (bubble) begin
      ctrl_d = CTRL_NOP;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= CTRL_NOP;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      funct_q <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc_q    <= bus.PC_i;
      rd1_q   <= bus.Read_Data_1_i;
      rd2_q   <= bus.Read_Data_2_i;
      imm_q   <= bus.Immediate_i;
      rs1_q   <= bus.Rs1_i;
      rs2_q   <= bus.Rs2_i;
      rd_q    <= bus.Rd_i;
      funct_q <= bus.Funct_i;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.Jal_o          = ctrl_q.jal;
  assign bus.Branch_o       = ctrl_q.branch;
  assign bus.Mem_to_Reg_o   = ctrl_q.mem_to_reg;
  assign bus.Reg_Write_o    = ctrl_q.reg_write;
  assign bus.Mem_Read_o     = ctrl_q.mem_read;
  assign bus.Mem_Write_o    = ctrl_q.mem_write;
  assign bus.ALU_Src_o      = ctrl_q.alu_src;
  assign bus.ALU_Op_o       = ctrl_q.alu_op;
  assign bus.PC_o           = pc_q;
  assign bus.Read_Data_1_o  = rd1_q;
  assign bus.Read_Data_2_o  = rd2_q;
  assign bus.Immediate_o    = imm_q;
  assign bus.Rs1_o          = rs1_q;
  assign bus.Rs2_o          = rs2_q;
  assign bus.Rd_o           = rd_q;
  assign bus.Funct_o        = funct_q;
  assign bus.Stall_o        = stall;
  assign bus.Bubble_Count_o = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for the ID/EX stage: reset, pass-through, load-use stalls,
// x0 and no-dependence cases, flush priority and counter saturation.
module tb_id_ex_hazard_stage;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  id_ex_hazard_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_hazard_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] ctrl_o;
  assign ctrl_o = {bus.Jal_o, bus.Branch_o, bus.Mem_to_Reg_o, bus.Reg_Write_o,
                   bus.Mem_Read_o, bus.Mem_Write_o, bus.ALU_Src_o, bus.ALU_Op_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic jal, input logic br, input logic mtr, input logic rw,
                          input logic mr, input logic mw, input logic src, input logic [2:0] op);
    bus.Jal_i = jal; bus.Branch_i = br; bus.Mem_to_Reg_i = mtr; bus.Reg_Write_i = rw;
    bus.Mem_Read_i = mr; bus.Mem_Write_i = mw; bus.ALU_Src_i = src; bus.ALU_Op_i = op;
  endtask

  task automatic set_idx(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    bus.Rs1_i = rs1; bus.Rs2_i = rs2; bus.Rd_i = rd;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    set_ctrl(0, 0, 0, 1, 0, 0, 0, 3'b000);
    set_idx(5'd1, 5'd2, 5'd3);
    bus.PC_i = 32'h40; bus.Read_Data_1_i = 32'h0; bus.Read_Data_2_i = 32'h0;
    bus.Immediate_i = 32'h0; bus.Funct_i = 4'h0; bus.Flush_i = 1'b0;

    // reset holds everything at zero even with live inputs
    tick(); tick();
    chk("rst_ctrl", {22'd0, ctrl_o}, 32'd0);
    chk("rst_pc", bus.PC_o, 32'd0);
    chk("rst_rd", {27'd0, bus.Rd_o}, 32'd0);
    chk("rst_stall", {31'd0, bus.Stall_o}, 32'd0);
    chk("rst_cnt", {28'd0, bus.Bubble_Count_o}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_rw", {31'd0, bus.Reg_Write_o}, 32'd1);
    chk("rel_pc", bus.PC_o, 32'h40);

    // R-type pass-through
    set_ctrl(0, 0, 0, 1, 0, 0, 0, 3'b000);
    set_idx(5'd1, 5'd2, 5'd5);
    bus.PC_i = 32'h44; bus.Read_Data_1_i = 32'h11; bus.Read_Data_2_i = 32'h22;
    bus.Immediate_i = 32'hFFFF_FFF0; bus.Funct_i = 4'b1000;
    tick();
    chk("pt_ctrl", {22'd0, ctrl_o}, {22'd0, 10'b0001000000});
    chk("pt_rd", {27'd0, bus.Rd_o}, 32'd5);
    chk("pt_rd1", bus.Read_Data_1_o, 32'h11);
    chk("pt_rd2", bus.Read_Data_2_o, 32'h22);
    chk("pt_imm", bus.Immediate_o, 32'hFFFF_FFF0);
    chk("pt_funct", {28'd0, bus.Funct_o}, 32'h8);
    chk("pt_rs", {22'd0, bus.Rs1_o, bus.Rs2_o}, {22'd0, 5'd1, 5'd2});
    chk("pt_pc", bus.PC_o, 32'h44);
    chk("pt_cnt", {28'd0, bus.Bubble_Count_o}, 32'd0);

    // jump/branch/store bits pass straight through
    set_ctrl(1, 1, 0, 0, 0, 1, 0, 3'b110);
    set_idx(5'd5, 5'd6, 5'd0);
    tick();
    chk("pt2_ctrl", {22'd0, ctrl_o}, {22'd0, 10'b1100010110});

    // load-use on rs1: one stall, one bubble, then the dependent op
    set_ctrl(0, 0, 1, 1, 1, 0, 1, 3'b101);
    set_idx(5'd2, 5'd0, 5'd7);
    #1;
    chk("lu_pre_stall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("lu_load_mr", {31'd0, bus.Mem_Read_o}, 32'd1);
    set_ctrl(0, 0, 0, 1, 0, 0, 0, 3'b000);
    set_idx(5'd7, 5'd3, 5'd8);
    #1;
    chk("lu_stall", {31'd0, bus.Stall_o}, 32'd1);
    tick();
    chk("lu_bub_ctrl", {22'd0, ctrl_o}, 32'd0);
    chk("lu_bub_cnt", {28'd0, bus.Bubble_Count_o}, 32'd1);
    chk("lu_bub_rd", {27'd0, bus.Rd_o}, 32'd8);
    chk("lu_unstall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("lu_dep_ctrl", {22'd0, ctrl_o}, {22'd0, 10'b0001000000});
    chk("lu_dep_cnt", {28'd0, bus.Bubble_Count_o}, 32'd1);

    // chain: load x10, load x11 using x10 via rs2, op using x11
    set_ctrl(0, 0, 1, 1, 1, 0, 1, 3'b101);
    set_idx(5'd1, 5'd0, 5'd10);
    tick();
    set_idx(5'd1, 5'd10, 5'd11);
    #1;
    chk("ch1_stall", {31'd0, bus.Stall_o}, 32'd1);
    tick();
    chk("ch1_cnt", {28'd0, bus.Bubble_Count_o}, 32'd2);
    chk("ch1_unstall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("ch1_load", {31'd0, bus.Mem_Read_o}, 32'd1);
    chk("ch1_rd", {27'd0, bus.Rd_o}, 32'd11);
    set_ctrl(0, 0, 0, 1, 0, 0, 0, 3'b000);
    set_idx(5'd11, 5'd4, 5'd12);
    #1;
    chk("ch2_stall", {31'd0, bus.Stall_o}, 32'd1);
    tick();
    chk("ch2_cnt", {28'd0, bus.Bubble_Count_o}, 32'd3);
    chk("ch2_unstall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("ch2_op", {31'd0, bus.Reg_Write_o}, 32'd1);

    // load into x0 never stalls; unrelated sources never stall
    set_ctrl(0, 0, 1, 1, 1, 0, 1, 3'b101);
    set_idx(5'd1, 5'd2, 5'd0);
    tick();
    set_idx(5'd0, 5'd0, 5'd9);
    #1;
    chk("x0_stall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    set_ctrl(0, 0, 0, 1, 0, 0, 0, 3'b000);
    set_idx(5'd3, 5'd4, 5'd13);
    #1;
    chk("nodep_stall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("nodep_cnt", {28'd0, bus.Bubble_Count_o}, 32'd3);

    // flush together with a hazard: no stall, a single bubble
    set_ctrl(0, 0, 1, 1, 1, 0, 1, 3'b101);
    set_idx(5'd1, 5'd2, 5'd14);
    tick();
    set_ctrl(1, 1, 0, 1, 0, 1, 1, 3'b011);
    set_idx(5'd14, 5'd0, 5'd15);
    bus.Flush_i = 1'b1;
    #1;
    chk("fl_stall", {31'd0, bus.Stall_o}, 32'd0);
    tick();
    chk("fl_ctrl", {22'd0, ctrl_o}, 32'd0);
    chk("fl_cnt", {28'd0, bus.Bubble_Count_o}, 32'd4);

    // saturate the 4-bit counter, then async reset mid-flush
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt", {28'd0, bus.Bubble_Count_o}, 32'hF);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_cnt", {28'd0, bus.Bubble_Count_o}, 32'd0);
    chk("midrst_pc", bus.PC_o, 32'd0);
    chk("midrst_rd", {27'd0, bus.Rd_o}, 32'd0);
    bus.Flush_i = 1'b0;
    tick();
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
